// File: rtl/tx_cpl_encode.sv
// tx_cpl_encode: builds single-beat PCIe completion TLPs (CplD or UR Cpl) for
// non-posted reads and presents them on the 256-bit HIP TX Avalon-ST port.
// One completion is in flight at a time; oDONE_PULSE releases the RX decoder.
module tx_cpl_encode #(
  parameter int BALI     = 0,
  parameter int STALL_TO = 1024
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iCPL_REQ,
  input  logic         iCPL_UR,
  input  logic [15:0]  iCPL_REQ_ID,
  input  logic [7:0]   iCPL_TAG,
  input  logic [2:0]   iCPL_TC,
  input  logic [1:0]   iCPL_ATTR,
  input  logic [4:0]   iCPL_ADDR,
  input  logic [9:0]   iCPL_LEN,
  input  logic [63:0]  iCPL_RD_DATA,
  input  logic [12:0]  iCFG_BUSDEV,
  output logic         oCPL_BUSY,
  output logic         oDONE_PULSE,
  output logic [255:0] oTX_ST_DATA,
  output logic         oTX_ST_SOP,
  output logic         oTX_ST_EOP,
  output logic         oTX_ST_VALID,
  output logic [1:0]   oTX_ST_EMPTY,
  output logic         oTX_ST_ERR,
  input  logic         iTX_ST_READY,
  output logic         oTX_STALL,
  input  logic         iSTALL_CLR
);

  localparam int CNT_W = $clog2(STALL_TO + 1);

  typedef enum logic [2:0] {IDLE, BUILD, PIPE, SEND, DONE} state_t;

  state_t             state;
  state_t             stateNext;
  logic               accept;
  logic               stallHit;
  logic [CNT_W-1:0]   stallCnt;

  logic               ur_p0;
  logic [15:0]        reqId_p0;
  logic [7:0]         tag_p0;
  logic [2:0]         tc_p0;
  logic [1:0]         attr_p0;
  logic [4:0]         addr_p0;
  logic [9:0]         len_p0;
  logic [63:0]        rdData_p0;
  logic [12:0]        busDev_p0;

  logic [255:0]       beat_p1;
  logic [1:0]         empty_p1;
  logic [255:0]       beat_p2;
  logic [1:0]         empty_p2;

  // Forms the whole beat {empty, data}. Lengths other than 1 or 2 DW are
  // answered with UR since the BAR read path only ever returns up to one QW.
  function automatic logic [257:0] buildBeat(
    input logic        ur,
    input logic [15:0] reqId,
    input logic [7:0]  tag,
    input logic [2:0]  tc,
    input logic [1:0]  attr,
    input logic [4:0]  addr,
    input logic [9:0]  len,
    input logic [63:0] rdData,
    input logic [12:0] busDev
  );
    logic            isUr;
    logic            qwAligned;
    logic            twoDw;
    logic [7:0][31:0] dw;
    logic [1:0]      empty;
    isUr      = ur || ((len != 10'd1) && (len != 10'd2));
    qwAligned = ~addr[0];
    twoDw     = (len == 10'd2);
    dw        = '0;
    dw[0] = {(isUr ? 8'h0A : 8'h4A), 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr,
             2'b00, (isUr ? 10'd0 : len)};
    dw[1] = {busDev, 3'b000, (isUr ? 3'b001 : 3'b000), 1'b0,
             (isUr ? 12'd4 : {len, 2'b00})};
    dw[2] = {reqId, tag, 1'b0, addr, 2'b00};
    empty = 2'd2;
    if (!isUr) begin
      // Aligned payload leaves DW3 as a zero pad so data sits on a QW boundary.
      if (qwAligned) begin
        dw[4] = rdData[31:0];
        if (twoDw) dw[5] = rdData[63:32];
      end else begin
        dw[3] = rdData[31:0];
        if (twoDw) dw[4] = rdData[63:32];
      end
      empty = (twoDw || qwAligned) ? 2'd1 : 2'd2;
    end
    return {empty, dw};
  endfunction

  assign accept = (state == IDLE) && iCPL_REQ;

  // ---- stage p0: request fields captured on the accept cycle only ----
  // Capture request fields so later input changes cannot disturb the TLP.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      ur_p0     <= iCPL_UR;
      reqId_p0  <= iCPL_REQ_ID;
      tag_p0    <= iCPL_TAG;
      tc_p0     <= iCPL_TC;
      attr_p0   <= iCPL_ATTR;
      addr_p0   <= iCPL_ADDR;
      len_p0    <= iCPL_LEN;
      rdData_p0 <= iCPL_RD_DATA;
      busDev_p0 <= iCFG_BUSDEV;
    end
  end

  // ---- stage p1: header and payload assembled during BUILD ----
  // Register the assembled beat at the end of BUILD.
  always_ff @(posedge iCLK) begin
    if (state == BUILD) begin
      {empty_p1, beat_p1} <= buildBeat(ur_p0, reqId_p0, tag_p0, tc_p0, attr_p0,
                                       addr_p0, len_p0, rdData_p0, busDev_p0);
    end
  end

  // ---- stage p2: optional retiming register for Gen3 timing closure ----
  generate
    if (BALI != 0) begin : gBali
      // Extra register stage loaded during PIPE.
      always_ff @(posedge iCLK) begin
        if (state == PIPE) begin
          beat_p2  <= beat_p1;
          empty_p2 <= empty_p1;
        end
      end
    end else begin : gNoBali
      assign beat_p2  = beat_p1;
      assign empty_p2 = empty_p1;
    end
  endgenerate

  // FSM state register; reset abandons any pending beat.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state and output decode; data is forced to 0 whenever no beat is valid.
  always_comb begin
    stateNext    = state;
    oCPL_BUSY    = (state != IDLE);
    oDONE_PULSE  = 1'b0;
    oTX_ST_VALID = 1'b0;
    oTX_ST_SOP   = 1'b0;
    oTX_ST_EOP   = 1'b0;
    oTX_ST_DATA  = '0;
    oTX_ST_EMPTY = '0;
    oTX_ST_ERR   = 1'b0;
    case (state)
      IDLE:  if (iCPL_REQ) stateNext = BUILD;
      BUILD: stateNext = (BALI != 0) ? PIPE : SEND;
      PIPE:  stateNext = SEND;
      SEND: begin
        oTX_ST_VALID = 1'b1;
        oTX_ST_SOP   = 1'b1;
        oTX_ST_EOP   = 1'b1;
        oTX_ST_DATA  = beat_p2;
        oTX_ST_EMPTY = empty_p2;
        if (iTX_ST_READY) stateNext = DONE;
      end
      DONE: begin
        oDONE_PULSE = 1'b1;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign stallHit = (state == SEND) && !iTX_ST_READY &&
                    (stallCnt >= CNT_W'(STALL_TO - 1));

  // Count back-pressured cycles of a pending beat; saturate at the timeout.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stallCnt <= '0;
    end else if ((state == SEND) && !iTX_ST_READY) begin
      if (stallCnt != CNT_W'(STALL_TO)) stallCnt <= stallCnt + CNT_W'(1);
    end else begin
      stallCnt <= '0;
    end
  end

  // Sticky timeout flag; software clear takes priority over a new hit.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)            oTX_STALL <= 1'b0;
    else if (iSTALL_CLR) oTX_STALL <= 1'b0;
    else if (stallHit)   oTX_STALL <= 1'b1;
  end

endmodule

// File: tb/tb_tx_cpl_encode.sv
// tb_tx_cpl_encode: directed bench for tx_cpl_encode. Expected beats are
// hand-derived and queued when a request is issued, then popped when the DUT
// presents its beat. dutA has BALI=0, dutB has BALI=1; both use STALL_TO=4.
module tb_tx_cpl_encode;

  logic         clk = 1'b0;
  logic         rst;
  logic         reqA, reqB, ur;
  logic [15:0]  reqId;
  logic [7:0]   tag;
  logic [2:0]   tc;
  logic [1:0]   attr;
  logic [4:0]   addr;
  logic [9:0]   len;
  logic [63:0]  rdData;
  logic [12:0]  busDev;
  logic         readyA, readyB, stallClr;

  logic         busyA, doneA, sopA, eopA, validA, errA, stallA;
  logic [255:0] dataA;
  logic [1:0]   emptyA;
  logic         busyB, doneB, sopB, eopB, validB, errB, stallB;
  logic [255:0] dataB;
  logic [1:0]   emptyB;

  typedef struct packed {
    logic [255:0] d;
    logic [1:0]   e;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_cpl_encode #(.BALI(0), .STALL_TO(4)) dutA (
    .iCLK(clk), .iRST(rst), .iCPL_REQ(reqA), .iCPL_UR(ur), .iCPL_REQ_ID(reqId),
    .iCPL_TAG(tag), .iCPL_TC(tc), .iCPL_ATTR(attr), .iCPL_ADDR(addr),
    .iCPL_LEN(len), .iCPL_RD_DATA(rdData), .iCFG_BUSDEV(busDev),
    .oCPL_BUSY(busyA), .oDONE_PULSE(doneA), .oTX_ST_DATA(dataA),
    .oTX_ST_SOP(sopA), .oTX_ST_EOP(eopA), .oTX_ST_VALID(validA),
    .oTX_ST_EMPTY(emptyA), .oTX_ST_ERR(errA), .iTX_ST_READY(readyA),
    .oTX_STALL(stallA), .iSTALL_CLR(stallClr)
  );

  tx_cpl_encode #(.BALI(1), .STALL_TO(4)) dutB (
    .iCLK(clk), .iRST(rst), .iCPL_REQ(reqB), .iCPL_UR(ur), .iCPL_REQ_ID(reqId),
    .iCPL_TAG(tag), .iCPL_TC(tc), .iCPL_ATTR(attr), .iCPL_ADDR(addr),
    .iCPL_LEN(len), .iCPL_RD_DATA(rdData), .iCFG_BUSDEV(busDev),
    .oCPL_BUSY(busyB), .oDONE_PULSE(doneB), .oTX_ST_DATA(dataB),
    .oTX_ST_SOP(sopB), .oTX_ST_EOP(eopB), .oTX_ST_VALID(validB),
    .oTX_ST_EMPTY(emptyB), .oTX_ST_ERR(errB), .iTX_ST_READY(readyB),
    .oTX_STALL(stallB), .iSTALL_CLR(stallClr)
  );

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [31:0] d0, d1, d2, d3, d4, d5);
    return {64'd0, d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic vld(input bit b);
    return b ? validB : validA;
  endfunction

  // Drive one request at the current cycle and queue its expected beat.
  task automatic issue(input bit b, input bit hold, input logic u, input logic [15:0] rid,
                       input logic [7:0] tg, input logic [2:0] t, input logic [1:0] at,
                       input logic [4:0] ad, input logic [9:0] ln, input logic [63:0] rd,
                       input logic [255:0] expD, input logic [1:0] expE);
    ur = u; reqId = rid; tag = tg; tc = t; attr = at; addr = ad; len = ln; rdData = rd;
    if (b) reqB = 1'b1; else reqA = 1'b1;
    sb.push_back('{d: expD, e: expE});
    tick();
    if (!hold) begin
      reqA = 1'b0;
      reqB = 1'b0;
    end
  endtask

  // Wait for the beat, compare it against the scoreboard, hold READY low for
  // lowCycles, then check the single transfer and the DONE pulse.
  task automatic expectBeat(input bit b, input string name, input int lat, input int lowCycles);
    int   n;
    exp_t e;
    n = 1;
    while (!vld(b) && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 256'(n), 256'(lat));
    if (sb.size() == 0) begin
      chk({name, "_sb_nonempty"}, 256'(0), 256'(1));
      return;
    end
    e = sb.pop_front();
    chk({name, "_data"},  b ? dataB : dataA, e.d);
    chk({name, "_empty"}, 256'(b ? emptyB : emptyA), 256'(e.e));
    chk({name, "_sop_eop_busy"}, 256'(b ? {sopB, eopB, busyB} : {sopA, eopA, busyA}), 256'(3'b111));
    for (int k = 0; k < lowCycles; k++) begin
      tick();
      chk({name, "_hold_valid"}, 256'(vld(b)), 256'(1));
      chk({name, "_hold_data"},  b ? dataB : dataA, e.d);
      chk({name, "_hold_done"},  256'(b ? doneB : doneA), 256'(0));
    end
    if (b) readyB = 1'b1; else readyA = 1'b1;
    tick();
    reqA = 1'b0;
    reqB = 1'b0;
    chk({name, "_post_valid_done"}, 256'({vld(b), b ? doneB : doneA}), 256'(2'b01));
    chk({name, "_post_data"}, b ? dataB : dataA, 256'(0));
    tick();
    chk({name, "_idle_done_busy"}, 256'(b ? {doneB, busyB} : {doneA, busyA}), 256'(2'b00));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; reqA = 1'b0; reqB = 1'b0; ur = 1'b0; reqId = '0; tag = '0; tc = '0;
    attr = '0; addr = '0; len = '0; rdData = '0; busDev = 13'h0A5;
    readyA = 1'b1; readyB = 1'b1; stallClr = 1'b0;
    repeat (3) tick();
    chk("reset_outA", {dataA[250:0], busyA, doneA, sopA, eopA, validA},
        256'(0));
    chk("reset_miscA", 256'({emptyA, errA, stallA, dataA[255:251]}), 256'(0));
    chk("reset_outB", {dataB[250:0], busyB, doneB, sopB, eopB, validB}, 256'(0));
    chk("reset_miscB", 256'({emptyB, errB, stallB, dataB[255:251]}), 256'(0));
    rst = 1'b0;
    tick();

    // CplD len1 unaligned
    issue(0, 0, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    expectBeat(0, "len1_unal", 2, 0);

    // CplD len2 aligned, TC/ATTR echoed
    issue(0, 0, 1'b0, 16'hABCD, 8'h34, 3'd5, 2'd2, 5'h02, 10'd2, 64'h1122334455667788,
          mk(32'h4A502002, 32'h05280008, 32'hABCD3408, 32'h0, 32'h55667788, 32'h11223344), 2'd1);
    expectBeat(0, "len2_al", 2, 0);

    // UR via iCPL_UR
    issue(0, 0, 1'b1, 16'h0200, 8'h77, 3'd0, 2'd0, 5'h01, 10'd1, 64'h1234_5678_9ABC_DEF0,
          mk(32'h0A000000, 32'h05282004, 32'h02007704, 32'h0, 32'h0, 32'h0), 2'd2);
    expectBeat(0, "ur_flag", 2, 0);

    // UR via unsupported length 4
    issue(0, 0, 1'b0, 16'h0300, 8'h01, 3'd1, 2'd0, 5'h00, 10'd4, 64'hFFFF_FFFF_FFFF_FFFF,
          mk(32'h0A100000, 32'h05282004, 32'h03000100, 32'h0, 32'h0, 32'h0), 2'd2);
    expectBeat(0, "ur_len4", 2, 0);

    // CplD len1 aligned: upper read data ignored
    issue(0, 0, 1'b0, 16'h0100, 8'h55, 3'd0, 2'd0, 5'h04, 10'd1, 64'hFFFF_FFFF_CAFE_F00D,
          mk(32'h4A000001, 32'h05280004, 32'h01005510, 32'h0, 32'hCAFEF00D, 32'h0), 2'd1);
    expectBeat(0, "len1_al", 2, 0);

    // CplD len2 unaligned
    issue(0, 0, 1'b0, 16'h0100, 8'h66, 3'd0, 2'd0, 5'h07, 10'd2, 64'h99AABBCC_DDEEFF00,
          mk(32'h4A000002, 32'h05280008, 32'h0100661C, 32'hDDEEFF00, 32'h99AABBCC, 32'h0), 2'd1);
    expectBeat(0, "len2_unal", 2, 0);

    // Short back-pressure below the timeout
    readyA = 1'b0;
    issue(0, 0, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    expectBeat(0, "bp3", 2, 3);
    chk("bp3_no_stall", 256'(stallA), 256'(0));

    // Back-pressure past the timeout: stall flag is sticky until cleared
    readyA = 1'b0;
    issue(0, 0, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    expectBeat(0, "bp5", 2, 5);
    chk("bp5_stall_set", 256'(stallA), 256'(1));
    tick();
    chk("bp5_stall_sticky", 256'(stallA), 256'(1));
    stallClr = 1'b1;
    tick();
    stallClr = 1'b0;
    chk("stall_cleared", 256'(stallA), 256'(0));

    // Request held high while busy, inputs changed after accept
    issue(0, 1, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    tag = 8'hFF; rdData = 64'h0; len = 10'd2;
    expectBeat(0, "busy_ignore", 2, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (validA) cnt++;
      tick();
    end
    chk("busy_one_tlp", 256'(cnt), 256'(0));
    chk("sb_drained", 256'(sb.size()), 256'(0));

    // Reset in the middle of SEND drops the beat with no DONE
    readyA = 1'b0;
    issue(0, 0, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    tick();
    chk("rst_pre_valid", 256'(validA), 256'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {dataA[251:0], validA, sopA, eopA, busyA}, 256'(0));
    void'(sb.pop_front());
    tick();
    rst = 1'b0;
    readyA = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (doneA || validA) cnt++;
      tick();
    end
    chk("rst_no_done", 256'(cnt), 256'(0));

    // BALI=1 rerun of the first case: same beat one cycle later
    issue(1, 0, 1'b0, 16'h0100, 8'h12, 3'd0, 2'd0, 5'h03, 10'd1, 64'h0000_0000_DEAD_BEEF,
          mk(32'h4A000001, 32'h05280004, 32'h0100120C, 32'hDEADBEEF, 32'h0, 32'h0), 2'd2);
    expectBeat(1, "bali_len1", 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
